sync_filter: RTL
================

# sync_filter

Multi-channel clock-domain input conditioner, the parametrised successor of the two-flop `sync` cell. It brings `WIDTH` asynchronous single-bit signals into the `clk_i` domain through an `STAGES`-deep synchroniser chain per channel. A per-channel persistence (debounce) filter rejects pulses shorter than `FILTER_CYCLES`, and optional one-cycle rise/fall event pulses are produced. It sits between external or foreign-domain inputs (buttons, GPIO, IRQ lines, handshake bits) and fabric logic.

## Interface
- `WIDTH`, default 1: number of independent channels; must be ≥ 1.
- `STAGES`, default 2: synchroniser flops per channel; must be ≥ 2.
- `FILTER_CYCLES`, default 1: consecutive cycles a synchronised value must persist before it is accepted; must be ≥ 1.
- `RESET_VALUE`, default `'0`: `WIDTH`-bit per-channel reset value for the chain and the filtered output.
- `clk_i`, input, 1: the single clock.
- `rst_i`, input, 1: reset, synchronous, active-high.
- `serial_i`, input, `WIDTH`: asynchronous inputs.
- `serial_o`, output, `WIDTH`: synchronised, filtered level.
- `rise_o`, output, `WIDTH`: one-cycle pulse when `serial_o[c]` goes 0→1.
- `fall_o`, output, `WIDTH`: one-cycle pulse when `serial_o[c]` goes 1→0.

## Operation
- Each channel operates independently; there is no cross-channel interaction.
- Synchroniser: a shift chain `chain[STAGES-1:0]` captures `serial_i[c]` into bit 0 on each edge. `s = chain[STAGES-1]`. Chain flops carry `async_reg`/`dont_touch` attributes.
- Filter state per channel: accepted level `q` (drives `serial_o`) and a counter `cnt` of width `$clog2(FILTER_CYCLES+1)`.
  - `s == q`: `cnt <= 0`; `q` holds.
  - `s != q` and `cnt == FILTER_CYCLES-1`: `q <= s`, `cnt <= 0`.
  - `s != q` otherwise: `cnt <= cnt+1`.
- A mismatch that disappears before acceptance clears `cnt` and leaves no trace. A counter never wraps; its maximum value is `FILTER_CYCLES-1`.
- `FILTER_CYCLES == 1`: `q` follows `s` with one register of delay, so there is no filtering.
- Edge pulses are registered in the same edge that updates `q`:
  - `rise_o[c] <= ~q & s & accept`
  - `fall_o[c] <= q & ~s & accept`
  - They are high exactly in the first cycle `serial_o[c]` shows the new level, and are never asserted together on one channel.
- Reset: on any edge with `rst_i = 1`:
  - `chain` and `q` load `RESET_VALUE`.
  - `cnt`, `rise_o` and `fall_o` load 0.
  - This applies mid-count or mid-pulse; a partially counted mismatch is discarded.
  - Reset itself never produces edge pulses, including at deassertion.
- Illegal parameters (`WIDTH < 1`, `STAGES < 2`, `FILTER_CYCLES < 1`) cause an elaboration-time `$error`.

## Timing
- Reset values: `serial_o = RESET_VALUE`, `rise_o = 0`, `fall_o = 0`.
- Latency: a level change present at `serial_i[c]` before edge 1 (and held) appears at `chain` output after edge `STAGES`. It appears on `serial_o[c]` and pulses `rise_o`/`fall_o` after edge `STAGES+FILTER_CYCLES`.
  - Default parameters give 3 cycles.
  - Asynchronous sampling adds up to one cycle of uncertainty.
- Minimum accepted pulse width at `s` is `FILTER_CYCLES` cycles. Shorter pulses are suppressed.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- Macro: `SYNC_FILTER_EDGE_DETECT_EN`.
- Defined: the `rise_o`/`fall_o` registers and logic are built as described above.
- Undefined:
  - `rise_o` and `fall_o` are tied to `'0`. The ports remain present so instantiations are unchanged.
  - No edge registers are inferred.
  - Level path behaviour is identical.

## Structure
- Package `sync_filter_pkg` contains:
  - Function `cnt_width(filter_cycles)` returning `$clog2(filter_cycles+1)`, with a minimum result of 1.
  - Shared limits `SYNC_MIN_STAGES = 2` and `SYNC_MIN_FILTER = 1`.
- Sub-module `sync_filter_chan` holds one channel's chain, filter counter, `q` and edge registers. The top generates `WIDTH` instances and performs parameter checks.

## Test plan
All scenarios use `WIDTH=4`, `STAGES=2`, `FILTER_CYCLES=4`, `RESET_VALUE=4'h0`, macro defined unless stated.
- Reset: `rst_i` held 3 cycles with `serial_i=4'hF` → `serial_o=4'h0` and no pulses during reset. After release, `serial_o=4'hF` and `rise_o=4'hF` for exactly one cycle after the 6th edge; no pulse at release itself.
- Glitch: `serial_i[0]` high for 3 cycles then low → `serial_o[0]` stays 0 and `rise_o[0]` never asserts. Repeat with 4 cycles → accepted, `rise_o[0]` pulses once, then `fall_o[0]` pulses after the return to 0.
- Step and independence: `serial_i[1]` 0→1 at edge 10, `serial_i[3]` 0→1 at edge 13 → `serial_o[1]` rises after edge 16 and `serial_o[3]` after edge 19, each with one `rise_o` pulse. Channels 0 and 2 are untouched.
- Reset mid-count: `serial_i[2]` goes high, `rst_i` pulsed one cycle during the 3rd mismatch cycle → `serial_o[2]=0` and no pulse. The full 6-cycle latency restarts from reset release.
- Bypass and macro off: `FILTER_CYCLES=1`, macro undefined, `serial_i=4'h5` → `serial_o=4'h5` after edge 3; `rise_o` and `fall_o` stay `4'h0` throughout.

Source files
------------

// File: rtl/sync_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_filter_pkg
// Description : Shared limits and helper function for the sync_filter
//               input conditioner (top and per-channel sub-module).
// Revision    : 1.0 - initial release
// ============================================================================
package sync_filter_pkg;

    // Smallest legal synchroniser depth and persistence filter length
    localparam int SYNC_MIN_STAGES = 2;
    localparam int SYNC_MIN_FILTER = 1;

    // Width of the persistence counter; never narrower than one bit
    function automatic int cnt_width(input int filter_cycles);
        int w;
        w = $clog2(filter_cycles + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_filter_chan.sv
`default_nettype none
// ============================================================================
// Module      : sync_filter_chan
// Description : One channel of sync_filter: STAGES-deep synchroniser chain,
//               persistence filter and optional registered rise/fall pulses.
//               Edge pulses are built only when SYNC_FILTER_EDGE_DETECT_EN
//               is defined; otherwise rise_o/fall_o are tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_filter_chan
    import sync_filter_pkg::*;
#(
    parameter int   STAGES        = 2,
    parameter int   FILTER_CYCLES = 1,
    parameter logic RESET_VALUE   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic serial_i,
    output logic serial_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int             CNT_W   = cnt_width(FILTER_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

    // Synchroniser flops must stay together and untouched by optimisation
    (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *)
    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    logic              q_q;
    logic              q_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic              w_sync;
    logic              w_mismatch;
    logic              w_accept;

    assign chain_d    = {chain_q[STAGES-2:0], serial_i};
    assign w_sync     = chain_q[STAGES-1];
    assign w_mismatch = w_sync ^ q_q;
    // A mismatch is accepted once it has persisted FILTER_CYCLES edges
    assign w_accept   = w_mismatch && (cnt_q == CNT_MAX);

    // Filter next state: count a persistent mismatch, clear it on agreement
    always_comb begin
        q_d   = q_q;
        cnt_d = cnt_q;
        if (!w_mismatch) begin
            cnt_d = '0;
        end else if (w_accept) begin
            q_d   = w_sync;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Chain, accepted level and counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chain_q <= {STAGES{RESET_VALUE}};
            q_q     <= RESET_VALUE;
            cnt_q   <= '0;
        end else begin
            chain_q <= chain_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
        end
    end

    assign serial_o = q_q;

`ifdef SYNC_FILTER_EDGE_DETECT_EN
    logic rise_q;
    logic fall_q;

    // Edge pulses register in the same edge that changes the accepted level
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= ~q_q &  w_sync & w_accept;
            fall_q <=  q_q & ~w_sync & w_accept;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`else
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/sync_filter.sv
`default_nettype none
// ============================================================================
// Module      : sync_filter
// Description : Multi-channel clock-domain input conditioner. WIDTH
//               independent channels, each synchronised, debounced and
//               optionally edge-detected. Edge detection is enabled by the
//               macro SYNC_FILTER_EDGE_DETECT_EN (ports always present).
// Revision    : 1.0 - initial release
// ============================================================================
module sync_filter
    import sync_filter_pkg::*;
#(
    parameter int               WIDTH         = 1,
    parameter int               STAGES        = 2,
    parameter int               FILTER_CYCLES = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] serial_i,
    output logic [WIDTH-1:0] serial_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    // Reject illegal configurations at elaboration
    if (WIDTH < 1) begin : g_chk_width
        $error("sync_filter: WIDTH must be >= 1");
    end
    if (STAGES < SYNC_MIN_STAGES) begin : g_chk_stages
        $error("sync_filter: STAGES must be >= 2");
    end
    if (FILTER_CYCLES < SYNC_MIN_FILTER) begin : g_chk_filter
        $error("sync_filter: FILTER_CYCLES must be >= 1");
    end

    // One fully independent conditioner per channel
    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        sync_filter_chan #(
            .STAGES        (STAGES),
            .FILTER_CYCLES (FILTER_CYCLES),
            .RESET_VALUE   (RESET_VALUE[i])
        ) u_chan (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .serial_i (serial_i[i]),
            .serial_o (serial_o[i]),
            .rise_o   (rise_o[i]),
            .fall_o   (fall_o[i])
        );
    end

endmodule
`default_nettype wire
